hazard_scoreboard: RTL and testbench

//  Parametrised, sequential successor to the decode-stage forwarding/stall logic.

---
 rtl/hazard_scoreboard_pkg.sv | 26 ++
 rtl/hazard_scoreboard_entry.sv | 52 +++++
 rtl/hazard_scoreboard.sv | 102 ++++++++++
 tb/tb_hazard_scoreboard.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard_pkg
// Description : Shared stage/latency encodings for the hazard scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_scoreboard_pkg;

    localparam int FWD_RF    = 0;
    localparam int STAGE_EX  = 1;
    localparam int STAGE_MEM = 2;
    localparam int STAGE_WB  = 3;
    localparam int LAT_ALU   = 1;
    localparam int LAT_LOAD  = 2;

    // A zero latency would never block anything, so it is lifted to ALU latency.
    function automatic int clamp_lat(input int lat, input int max_lat);
        if (lat < LAT_ALU)
            return LAT_ALU;
        if (lat > max_lat)
            return max_lat;
        return lat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard_entry.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard_entry
// Description : Pending/age/latency state for one architectural register.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard_entry #(
    parameter int WB_STAGES = 3,
    parameter int AGE_W     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set,
    input  logic [AGE_W-1:0] set_lat,
    input  logic             advance,
    output logic             pend,
    output logic [AGE_W-1:0] age,
    output logic [AGE_W-1:0] lat
);

    localparam logic [AGE_W-1:0] c_AGE_LAST = AGE_W'(WB_STAGES);

    logic             r_pend;
    logic [AGE_W-1:0] r_age;
    logic [AGE_W-1:0] r_lat;

    // A new writer replaces any older in-flight write to the same register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= 1'b0;
            r_age  <= '0;
            r_lat  <= '0;
        end else if (set) begin
            r_pend <= 1'b1;
            r_age  <= AGE_W'(1);
            r_lat  <= set_lat;
        end else if (advance && r_pend) begin
            if (r_age == c_AGE_LAST) begin
                r_pend <= 1'b0;
                r_age  <= '0;
            end else begin
                r_age  <= r_age + AGE_W'(1);
            end
        end
    end

    assign pend = r_pend;
    assign age  = r_age;
    assign lat  = r_lat;

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Decode-stage RAW stall and forwarding-select generator.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter  int NUM_REGS  = 32,
    parameter  int WB_STAGES = STAGE_WB,
    parameter  int CNT_W     = 32,
    localparam int RA_W      = $clog2(NUM_REGS),
    localparam int AGE_W     = $clog2(WB_STAGES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [RA_W-1:0]  rs_addr,
    input  logic             rs_used,
    input  logic [RA_W-1:0]  rt_addr,
    input  logic             rt_used,
    input  logic             wr_en,
    input  logic [RA_W-1:0]  wr_addr,
    input  logic [AGE_W-1:0] wr_lat,
    output logic [AGE_W-1:0] rs_fwd_sel,
    output logic [AGE_W-1:0] rt_fwd_sel,
    output logic [CNT_W-1:0] stall_cycles
);

    logic [NUM_REGS-1:0] w_pend;
    logic [AGE_W-1:0]    w_age [NUM_REGS];
    logic [AGE_W-1:0]    w_lat [NUM_REGS];

    logic             w_fire;
    logic             w_wr_go;
    logic [AGE_W-1:0] w_set_lat;

    logic             w_rs_pend, w_rt_pend;
    logic [AGE_W-1:0] w_rs_age, w_rt_age;
    logic [AGE_W-1:0] w_rs_lat, w_rt_lat;
    logic             w_rs_nz, w_rt_nz;
    logic             w_haz_rs, w_haz_rt;

    logic [CNT_W-1:0] r_stall_cycles;

    assign w_fire    = issue_valid & issue_ready & ~hold;
    assign w_wr_go   = w_fire & wr_en & (wr_addr != '0);
    assign w_set_lat = AGE_W'(clamp_lat(int'(wr_lat), WB_STAGES));

    // r0 is hardwired zero and therefore never pending.
    assign w_pend[0] = 1'b0;
    assign w_age[0]  = '0;
    assign w_lat[0]  = '0;

    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_entry
        hazard_scoreboard_entry #(
            .WB_STAGES (WB_STAGES),
            .AGE_W     (AGE_W)
        ) u_entry (
            .clk     (clk),
            .rst     (rst),
            .set     (w_wr_go && (wr_addr == RA_W'(gi))),
            .set_lat (w_set_lat),
            .advance (~hold),
            .pend    (w_pend[gi]),
            .age     (w_age[gi]),
            .lat     (w_lat[gi])
        );
    end

    assign w_rs_pend = w_pend[rs_addr];
    assign w_rs_age  = w_age[rs_addr];
    assign w_rs_lat  = w_lat[rs_addr];
    assign w_rt_pend = w_pend[rt_addr];
    assign w_rt_age  = w_age[rt_addr];
    assign w_rt_lat  = w_lat[rt_addr];

    assign w_rs_nz = (rs_addr != '0);
    assign w_rt_nz = (rt_addr != '0);

    // Result not yet produced by the stage it will be forwarded from.
    assign w_haz_rs = rs_used & w_rs_nz & w_rs_pend & (w_rs_age < w_rs_lat);
    assign w_haz_rt = rt_used & w_rt_nz & w_rt_pend & (w_rt_age < w_rt_lat);

    assign issue_ready = ~(w_haz_rs | w_haz_rt);
    assign rs_fwd_sel  = (w_rs_nz && w_rs_pend) ? w_rs_age : AGE_W'(FWD_RF);
    assign rt_fwd_sel  = (w_rt_nz && w_rt_pend) ? w_rt_age : AGE_W'(FWD_RF);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_stall_cycles <= '0;
        else if (issue_valid && !issue_ready && !hold && (r_stall_cycles != '1))
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end

    assign stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Directed scenarios plus random stimulus against a timeline model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    localparam int NUM_REGS = 32;
    localparam int WB       = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hold = 1'b0;
    logic        issue_valid = 1'b0;
    logic        rs_used = 1'b0;
    logic        rt_used = 1'b0;
    logic        wr_en = 1'b0;
    logic [4:0]  rs_addr = '0;
    logic [4:0]  rt_addr = '0;
    logic [4:0]  wr_addr = '0;
    logic [1:0]  wr_lat = '0;
    logic        issue_ready;
    logic [1:0]  rs_fwd_sel;
    logic [1:0]  rt_fwd_sel;
    logic [31:0] stall_cycles;

    int total = 0;
    int bad   = 0;

    // Model: each register remembers when (in unfrozen cycles) its latest write issued.
    int now;
    int last_issue [NUM_REGS];
    int last_lat   [NUM_REGS];
    int exp_stall;

    hazard_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .hold         (hold),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .rs_addr      (rs_addr),
        .rs_used      (rs_used),
        .rt_addr      (rt_addr),
        .rt_used      (rt_used),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_lat       (wr_lat),
        .rs_fwd_sel   (rs_fwd_sel),
        .rt_fwd_sel   (rt_fwd_sel),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        now = 0;
        exp_stall = 0;
        for (int i = 0; i < NUM_REGS; i++) begin
            last_issue[i] = -1000;
            last_lat[i]   = 0;
        end
    endfunction

    function automatic int m_age(input int a);
        return now - last_issue[a];
    endfunction

    function automatic bit m_pend(input int a);
        return (a != 0) && (m_age(a) >= 1) && (m_age(a) <= WB);
    endfunction

    function automatic bit m_haz(input bit used, input int a);
        return used && m_pend(a) && (m_age(a) < last_lat[a]);
    endfunction

    function automatic bit m_ready();
        return !(m_haz(rs_used, int'(rs_addr)) || m_haz(rt_used, int'(rt_addr)));
    endfunction

    function automatic logic [1:0] m_sel(input int a);
        return m_pend(a) ? 2'(m_age(a)) : 2'd0;
    endfunction

    task automatic tick();
        bit rdy;
        int lat;
        rdy = m_ready();
        @(posedge clk);
        if (!hold) begin
            if (issue_valid && !rdy)
                exp_stall++;
            if (issue_valid && rdy && wr_en && wr_addr != 0) begin
                lat = int'(wr_lat);
                if (lat < 1) lat = 1;
                if (lat > WB) lat = WB;
                last_issue[wr_addr] = now;
                last_lat[wr_addr]   = lat;
            end
            now++;
        end
        #1;
    endtask

    task automatic drive(input bit v, input bit h, input int rs, input bit rsu,
                         input int rt, input bit rtu, input bit we, input int wa, input int wl);
        issue_valid = v;  hold = h;
        rs_addr = 5'(rs); rs_used = rsu;
        rt_addr = 5'(rt); rt_used = rtu;
        wr_en = we; wr_addr = 5'(wa); wr_lat = 2'(wl);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, $urandom_range(1, 31), 1, $urandom_range(1, 31), 1, 0, 0, 0);
            #1;
            total++;
            if (issue_ready !== 1'b1 || rs_fwd_sel !== 2'd0 || rt_fwd_sel !== 2'd0) begin
                bad++;
                $display("FAIL reset_outputs ready=%0b rs_sel=%0d rt_sel=%0d required 1/0/0",
                         issue_ready, rs_fwd_sel, rt_fwd_sel);
            end
        end
        total++;
        if (stall_cycles !== 32'd0) begin
            bad++;
            $display("FAIL reset_stall got=%0d required=0", stall_cycles);
        end
    endtask

    task automatic test_alu_chain();
        int exp_sel [4] = '{1, 2, 3, 0};
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 1, 3, 1);
        tick();
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 3, 1, 0, 0, 0, 0, 0);
            #1;
            total++;
            if (issue_ready !== 1'b1 || rs_fwd_sel !== 2'(exp_sel[k])) begin
                bad++;
                $display("FAIL alu_chain k=%0d ready=%0b sel=%0d required ready=1 sel=%0d",
                         k, issue_ready, rs_fwd_sel, exp_sel[k]);
            end
            tick();
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 1, 4, 2);
        tick();
        drive(1, 0, 0, 0, 4, 1, 0, 0, 0);
        #1;
        total++;
        if (issue_ready !== 1'b0) begin
            bad++;
            $display("FAIL load_use_stall ready=%0b required=0", issue_ready);
        end
        tick();
        total++;
        if (issue_ready !== 1'b1 || rt_fwd_sel !== 2'd2 || stall_cycles !== 32'd1) begin
            bad++;
            $display("FAIL load_use_release ready=%0b sel=%0d stall=%0d required 1/2/1",
                     issue_ready, rt_fwd_sel, stall_cycles);
        end
    endtask

    task automatic test_zero_unused();
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 1, 0, 2);
        tick();
        drive(1, 0, 0, 1, 0, 0, 1, 5, 2);
        #1;
        total++;
        if (issue_ready !== 1'b1 || rs_fwd_sel !== 2'd0) begin
            bad++;
            $display("FAIL zero_reg ready=%0b sel=%0d required 1/0", issue_ready, rs_fwd_sel);
        end
        tick();
        drive(1, 0, 5, 0, 0, 0, 0, 0, 0);
        #1;
        total++;
        if (issue_ready !== 1'b1 || rs_fwd_sel !== 2'd1) begin
            bad++;
            $display("FAIL unused_operand ready=%0b sel=%0d required 1/1", issue_ready, rs_fwd_sel);
        end
    endtask

    task automatic test_hold();
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 1, 4, 2);
        tick();
        drive(1, 1, 4, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            #1;
            total++;
            if (issue_ready !== 1'b0 || stall_cycles !== 32'd0) begin
                bad++;
                $display("FAIL hold_frozen k=%0d ready=%0b stall=%0d required 0/0",
                         k, issue_ready, stall_cycles);
            end
            tick();
        end
        hold = 1'b0;
        #1;
        total++;
        if (issue_ready !== 1'b0) begin
            bad++;
            $display("FAIL hold_release_stall ready=%0b required=0", issue_ready);
        end
        tick();
        total++;
        if (issue_ready !== 1'b1 || rs_fwd_sel !== 2'd2 || stall_cycles !== 32'd1) begin
            bad++;
            $display("FAIL hold_release_ready ready=%0b sel=%0d stall=%0d required 1/2/1",
                     issue_ready, rs_fwd_sel, stall_cycles);
        end
    endtask

    task automatic test_overwrite();
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 1, 6, 2);
        tick();
        drive(1, 0, 0, 0, 0, 0, 1, 6, 1);
        tick();
        drive(1, 0, 6, 1, 0, 0, 0, 0, 0);
        #1;
        total++;
        if (issue_ready !== 1'b1 || rs_fwd_sel !== 2'd1) begin
            bad++;
            $display("FAIL overwrite ready=%0b sel=%0d required 1/1", issue_ready, rs_fwd_sel);
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 1, 7, 3);
        tick();
        drive(1, 0, 7, 1, 0, 0, 0, 0, 0);
        tick();
        total++;
        if (issue_ready !== 1'b0 || rs_fwd_sel !== 2'd2 || stall_cycles !== 32'd1) begin
            bad++;
            $display("FAIL midflight_pre ready=%0b sel=%0d stall=%0d required 0/2/1",
                     issue_ready, rs_fwd_sel, stall_cycles);
        end
        #1;
        rst = 1'b1;
        #1;
        total++;
        if (issue_ready !== 1'b1 || rs_fwd_sel !== 2'd0 || stall_cycles !== 32'd0) begin
            bad++;
            $display("FAIL midflight_async ready=%0b sel=%0d stall=%0d required 1/0/0",
                     issue_ready, rs_fwd_sel, stall_cycles);
        end
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 7), $urandom_range(0, 1),
                  $urandom_range(0, 7), $urandom_range(0, 1),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 7), $urandom_range(0, 3));
            #1;
            total++;
            if (issue_ready !== m_ready() || rs_fwd_sel !== m_sel(int'(rs_addr))
                || rt_fwd_sel !== m_sel(int'(rt_addr)) || stall_cycles !== 32'(exp_stall)) begin
                bad++;
                $display("FAIL random c=%0d ready=%0b/%0b rs_sel=%0d/%0d rt_sel=%0d/%0d stall=%0d/%0d (got/required)",
                         c, issue_ready, m_ready(), rs_fwd_sel, m_sel(int'(rs_addr)),
                         rt_fwd_sel, m_sel(int'(rt_addr)), stall_cycles, exp_stall);
            end
            tick();
        end
    endtask

    initial begin
        model_reset();
        #1;
        test_reset();
        test_alu_chain();
        test_load_use();
        test_zero_unused();
        test_hold();
        test_overwrite();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
